// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - command, response and stack-memory signals of the operand-stack sequencer
interface stack_ctrl_if #(
  parameter int DEPTH_BITS = 16
) ();

  // Command channel from decode/execute
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [31:0]           cmd_value;

  // Response channel back to execute
  logic                  rsp_valid;
  logic [31:0]           rsp_a;
  logic [31:0]           rsp_b;
  logic                  rsp_error;

  // Current stack occupancy
  logic [DEPTH_BITS:0]   depth;

  // Stack memory transaction port
  logic                  mem_push;
  logic                  mem_trigger;
  logic [31:0]           mem_write_value;
  logic [31:0]           mem_read_value;
  logic                  mem_done;

  // Sequencer side
  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_value,
    input  mem_read_value,
    input  mem_done,
    output cmd_ready,
    output rsp_valid,
    output rsp_a,
    output rsp_b,
    output rsp_error,
    output depth,
    output mem_push,
    output mem_trigger,
    output mem_write_value
  );

  // Execute stage / memory side
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_value,
    output mem_read_value,
    output mem_done,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_a,
    input  rsp_b,
    input  rsp_error,
    input  depth,
    input  mem_push,
    input  mem_trigger,
    input  mem_write_value
  );

endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - operand-stack sequencer splitting stack commands into single memory push/pop transactions
module stack_ctrl #(
  parameter int DEPTH_BITS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  stack_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP_A  = 3'd1,
    S_POP_B  = 3'd2,
    S_PUSH_1 = 3'd3,
    S_PUSH_2 = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_DUP  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_POP2 = 3'b101;

  // Full-stack count: one more bit than the address so a full stack is representable
  localparam logic [DEPTH_BITS:0] CAPACITY = {1'b1, {DEPTH_BITS{1'b0}}};

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_op;
  logic [31:0]           r_value;
  logic [31:0]           r_a;
  logic [31:0]           r_b;
  logic                  r_err;
  logic                  r_trig;
  logic [DEPTH_BITS:0]   r_depth;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_done;
  logic                  w_has1;
  logic                  w_has2;
  logic                  w_room;
  logic                  w_is_push_state;
  logic                  w_is_pop_state;
  logic                  w_next_is_micro;
  logic [31:0]           w_write_value;

  // Ready only while idle and out of reset
  assign w_ready  = (r_state == S_IDLE) && rst_n;
  assign w_accept = bus.cmd_valid && w_ready;

  // The cycle carrying the trigger pulse never counts as completion
  assign w_done   = bus.mem_done && !r_trig;

  assign w_has1   = (r_depth != '0);
  assign w_has2   = (r_depth >= (DEPTH_BITS+1)'(2));
  assign w_room   = (r_depth < CAPACITY);

  assign w_is_push_state = (r_state == S_PUSH_1) || (r_state == S_PUSH_2);
  assign w_is_pop_state  = (r_state == S_POP_A)  || (r_state == S_POP_B);
  assign w_next_is_micro = (w_next == S_POP_A)  || (w_next == S_POP_B) ||
                           (w_next == S_PUSH_1) || (w_next == S_PUSH_2);

  // Next-state decode: legality at accept, then walk the micro-op sequence of the latched op
  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_PUSH: begin
              if (w_room) w_next = S_PUSH_1;
              else begin
                w_next    = S_RESP;
                w_illegal = 1'b1;
              end
            end
            OP_POP: begin
              if (w_has1) w_next = S_POP_A;
              else begin
                w_next    = S_RESP;
                w_illegal = 1'b1;
              end
            end
            OP_DUP: begin
              if (w_has1 && w_room) w_next = S_POP_A;
              else begin
                w_next    = S_RESP;
                w_illegal = 1'b1;
              end
            end
            OP_SWAP, OP_POP2: begin
              if (w_has2) w_next = S_POP_A;
              else begin
                w_next    = S_RESP;
                w_illegal = 1'b1;
              end
            end
            default: w_next = S_RESP;
          endcase
        end
      end
      S_POP_A: begin
        if (w_done) begin
          case (r_op)
            OP_POP2, OP_SWAP: w_next = S_POP_B;
            OP_DUP:           w_next = S_PUSH_1;
            default:          w_next = S_RESP;
          endcase
        end
      end
      S_POP_B: begin
        if (w_done) begin
          if (r_op == OP_SWAP) w_next = S_PUSH_1;
          else                 w_next = S_RESP;
        end
      end
      S_PUSH_1: begin
        if (w_done) begin
          if (r_op == OP_PUSH) w_next = S_RESP;
          else                 w_next = S_PUSH_2;
        end
      end
      S_PUSH_2: begin
        if (w_done) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Push data: PUSH writes the latched command value, DUP writes a twice, SWAP writes a then b
  always_comb begin
    w_write_value = '0;
    case (r_state)
      S_PUSH_1: w_write_value = (r_op == OP_PUSH) ? r_value : r_a;
      S_PUSH_2: w_write_value = (r_op == OP_SWAP) ? r_b : r_a;
      default:  w_write_value = '0;
    endcase
  end

  // State register plus the one-cycle trigger raised on entry to any micro-op state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_trig  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trig  <= w_next_is_micro && (w_next != r_state);
    end
  end

  // Command capture at accept; the error flag describes the command currently finishing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_value <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= bus.cmd_op;
      r_value <= bus.cmd_value;
      r_err   <= w_illegal;
    end
  end

  // Popped operands, kept until the next pop overwrites them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_done) begin
      if (r_state == S_POP_A) r_a <= bus.mem_read_value;
      if (r_state == S_POP_B) r_b <= bus.mem_read_value;
    end
  end

  // Occupancy follows completed transactions; legality precheck keeps it in range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= '0;
    end else if (w_done) begin
      if (w_is_push_state)     r_depth <= r_depth + 1'b1;
      else if (w_is_pop_state) r_depth <= r_depth - 1'b1;
    end
  end

  assign bus.cmd_ready       = w_ready;
  assign bus.rsp_valid       = (r_state == S_RESP);
  assign bus.rsp_error       = (r_state == S_RESP) && r_err;
  assign bus.rsp_a           = r_a;
  assign bus.rsp_b           = r_b;
  assign bus.depth           = r_depth;
  assign bus.mem_trigger     = r_trig;
  assign bus.mem_push        = w_is_push_state;
  assign bus.mem_write_value = w_write_value;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl
module tb_stack_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_ctrl_if #(.DEPTH_BITS(16)) b0 ();
  stack_ctrl_if #(.DEPTH_BITS(2))  b1 ();

  stack_ctrl #(.DEPTH_BITS(16)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  stack_ctrl #(.DEPTH_BITS(2))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  c_valid = 2'b00;
  logic [2:0]  c_op    = 3'd0;
  logic [31:0] c_value = 32'd0;

  assign b0.cmd_valid = c_valid[0];
  assign b1.cmd_valid = c_valid[1];
  assign b0.cmd_op    = c_op;
  assign b1.cmd_op    = c_op;
  assign b0.cmd_value = c_value;
  assign b1.cmd_value = c_value;

  // Memory model for the 64K instance: a real stack, answering one cycle after trigger
  logic        m0_done   = 1'b0;
  logic        late_done = 1'b0;
  logic        hold0     = 1'b0;
  logic [31:0] m0_rd     = 32'd0;
  logic [31:0] stk [0:15];
  int          sp    = 0;
  int          trig0 = 0;
  logic [32:0] oplog [$];

  assign b0.mem_done       = m0_done | late_done;
  assign b0.mem_read_value = m0_rd;

  initial begin
    forever begin
      @(negedge clk);
      if (b0.mem_trigger === 1'b1) begin
        trig0++;
        oplog.push_back({b0.mem_push, b0.mem_write_value});
        if (!hold0) begin
          if (b0.mem_push) begin
            if (sp < 16) begin
              stk[sp] = b0.mem_write_value;
              sp++;
            end
          end else if (sp > 0) begin
            sp--;
            m0_rd = stk[sp];
          end
          @(posedge clk); #1 m0_done = 1'b1;
          @(posedge clk); #1 m0_done = 1'b0;
        end
      end
    end
  end

  // Memory model for the 4-entry instance: only completion timing matters
  logic m1_done = 1'b0;
  int   trig1   = 0;
  assign b1.mem_done       = m1_done;
  assign b1.mem_read_value = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (b1.mem_trigger === 1'b1) begin
        trig1++;
        @(posedge clk); #1 m1_done = 1'b1;
        @(posedge clk); #1 m1_done = 1'b0;
      end
    end
  end

  // Issue one command, return cycles from accept to rsp_valid and the error flag
  task automatic run_cmd(input int sel, input logic [2:0] op, input logic [31:0] val,
                         output int lat, output logic err);
    @(posedge clk); #1;
    c_op = op;
    c_value = val;
    c_valid[sel] = 1'b1;
    @(posedge clk); #1;
    c_valid[sel] = 1'b0;
    c_value = 32'hFFFF_FFFF;
    lat = 1;
    err = 1'b0;
    forever begin
      @(negedge clk);
      if ((sel == 0) ? b0.rsp_valid : b1.rsp_valid) begin
        err = (sel == 0) ? b0.rsp_error : b1.rsp_error;
        break;
      end
      if (lat >= 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, required within 60", lat);
        lat = -1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({b0.cmd_ready, b0.rsp_valid, b0.mem_trigger, b0.mem_push, b0.rsp_error} !== 5'b0 ||
        b0.depth !== 17'd0 || b0.rsp_a !== 32'd0 || b0.rsp_b !== 32'd0 || b0.mem_write_value !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b trig=%b depth=%0d a=%h b=%h, required all 0",
               b0.cmd_ready, b0.rsp_valid, b0.mem_trigger, b0.depth, b0.rsp_a, b0.rsp_b);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (b0.cmd_ready !== 1'b1 || b1.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b/%b, required 1/1", b0.cmd_ready, b1.cmd_ready);
    end
  endtask

  task automatic test_push();
    int lat;
    logic err;
    oplog.delete();
    run_cmd(0, 3'b001, 32'h0000_002A, lat, err);
    n_checks++;
    if (lat !== 3 || err !== 1'b0 || b0.depth !== 17'd1) begin
      n_fail++;
      $display("FAIL push_basic: lat=%0d err=%b depth=%0d, required lat=3 err=0 depth=1", lat, err, b0.depth);
    end
    n_checks++;
    if (oplog.size() != 1 || oplog[0] !== {1'b1, 32'h0000_002A}) begin
      n_fail++;
      $display("FAIL push_mem: %0d ops, first=%h, required 1 op = 10000002a", oplog.size(),
               (oplog.size() > 0) ? oplog[0] : 33'h0);
    end
    run_cmd(0, 3'b010, 32'd0, lat, err);
    n_checks++;
    if (lat !== 3 || err !== 1'b0 || b0.rsp_a !== 32'h2A || b0.depth !== 17'd0) begin
      n_fail++;
      $display("FAIL pop_basic: lat=%0d err=%b a=%h depth=%0d, required 3 0 2a 0", lat, err, b0.rsp_a, b0.depth);
    end
  endtask

  task automatic test_swap_pop2();
    int lat;
    logic err;
    run_cmd(0, 3'b001, 32'd5, lat, err);
    run_cmd(0, 3'b001, 32'd7, lat, err);
    oplog.delete();
    run_cmd(0, 3'b100, 32'd0, lat, err);
    n_checks++;
    if (lat !== 9 || err !== 1'b0 || b0.depth !== 17'd2 || b0.rsp_a !== 32'd7 || b0.rsp_b !== 32'd5) begin
      n_fail++;
      $display("FAIL swap_rsp: lat=%0d err=%b depth=%0d a=%h b=%h, required 9 0 2 7 5",
               lat, err, b0.depth, b0.rsp_a, b0.rsp_b);
    end
    n_checks++;
    if (oplog.size() != 4 || oplog[0][32] !== 1'b0 || oplog[1][32] !== 1'b0 ||
        oplog[2] !== {1'b1, 32'd7} || oplog[3] !== {1'b1, 32'd5}) begin
      n_fail++;
      $display("FAIL swap_seq: %0d ops, required pop pop push7 push5", oplog.size());
    end
    run_cmd(0, 3'b101, 32'd0, lat, err);
    n_checks++;
    if (lat !== 5 || err !== 1'b0 || b0.rsp_a !== 32'd5 || b0.rsp_b !== 32'd7 || b0.depth !== 17'd0) begin
      n_fail++;
      $display("FAIL pop2_after_swap: lat=%0d err=%b a=%h b=%h depth=%0d, required 5 0 5 7 0",
               lat, err, b0.rsp_a, b0.rsp_b, b0.depth);
    end
  endtask

  task automatic test_illegal();
    int lat;
    int t0;
    logic err;
    t0 = trig0;
    run_cmd(0, 3'b010, 32'd0, lat, err);
    n_checks++;
    if (lat !== 1 || err !== 1'b1 || trig0 != t0 || b0.depth !== 17'd0 || b0.rsp_a !== 32'd5) begin
      n_fail++;
      $display("FAIL pop_underflow: lat=%0d err=%b trig=%0d depth=%0d a=%h, required 1 1 0 0 5",
               lat, err, trig0 - t0, b0.depth, b0.rsp_a);
    end
    run_cmd(0, 3'b001, 32'hDEAD_BEEF, lat, err);
    t0 = trig0;
    run_cmd(0, 3'b100, 32'd0, lat, err);
    n_checks++;
    if (err !== 1'b1 || trig0 != t0 || b0.depth !== 17'd1 || b0.rsp_b !== 32'd7) begin
      n_fail++;
      $display("FAIL swap_underflow: err=%b trig=%0d depth=%0d b=%h, required 1 0 1 7",
               err, trig0 - t0, b0.depth, b0.rsp_b);
    end
  endtask

  task automatic test_dup();
    int lat;
    logic err;
    oplog.delete();
    run_cmd(0, 3'b011, 32'd0, lat, err);
    n_checks++;
    if (lat !== 7 || err !== 1'b0 || b0.depth !== 17'd2) begin
      n_fail++;
      $display("FAIL dup_rsp: lat=%0d err=%b depth=%0d, required 7 0 2", lat, err, b0.depth);
    end
    n_checks++;
    if (oplog.size() != 3 || oplog[0][32] !== 1'b0 ||
        oplog[1] !== {1'b1, 32'hDEAD_BEEF} || oplog[2] !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL dup_seq: %0d ops, required pop push deadbeef push deadbeef", oplog.size());
    end
    run_cmd(0, 3'b101, 32'd0, lat, err);
    n_checks++;
    if (err !== 1'b0 || b0.rsp_a !== 32'hDEAD_BEEF || b0.rsp_b !== 32'hDEAD_BEEF || b0.depth !== 17'd0) begin
      n_fail++;
      $display("FAIL dup_pop2: err=%b a=%h b=%h depth=%0d, required 0 deadbeef deadbeef 0",
               err, b0.rsp_a, b0.rsp_b, b0.depth);
    end
  endtask

  task automatic test_nop();
    int lat;
    int t0;
    logic err;
    t0 = trig0;
    run_cmd(0, 3'b000, 32'd0, lat, err);
    n_checks++;
    if (lat !== 1 || err !== 1'b0 || trig0 != t0) begin
      n_fail++;
      $display("FAIL nop: lat=%0d err=%b trig=%0d, required 1 0 0", lat, err, trig0 - t0);
    end
    run_cmd(0, 3'b111, 32'd0, lat, err);
    n_checks++;
    if (lat !== 1 || err !== 1'b0 || trig0 != t0 || b0.depth !== 17'd0) begin
      n_fail++;
      $display("FAIL op_reserved: lat=%0d err=%b trig=%0d depth=%0d, required 1 0 0 0",
               lat, err, trig0 - t0, b0.depth);
    end
  endtask

  task automatic test_capacity();
    int lat;
    logic err;
    for (int i = 1; i <= 4; i++) begin
      run_cmd(1, 3'b001, 32'(i), lat, err);
      n_checks++;
      if (err !== 1'b0 || b1.depth !== 3'(i)) begin
        n_fail++;
        $display("FAIL small_push%0d: err=%b depth=%0d, required 0 %0d", i, err, b1.depth, i);
      end
    end
    run_cmd(1, 3'b001, 32'd5, lat, err);
    n_checks++;
    if (err !== 1'b1 || b1.depth !== 3'd4 || trig1 != 4) begin
      n_fail++;
      $display("FAIL small_overflow: err=%b depth=%0d trig=%0d, required 1 4 4", err, b1.depth, trig1);
    end
    run_cmd(1, 3'b011, 32'd0, lat, err);
    n_checks++;
    if (err !== 1'b1 || b1.depth !== 3'd4 || trig1 != 4) begin
      n_fail++;
      $display("FAIL small_dup_full: err=%b depth=%0d trig=%0d, required 1 4 4", err, b1.depth, trig1);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int t0;
    logic err;
    logic saw_rsp;
    run_cmd(0, 3'b001, 32'h0000_0011, lat, err);
    hold0 = 1'b1;
    t0 = trig0;
    @(posedge clk); #1;
    c_op = 3'b010;
    c_valid[0] = 1'b1;
    @(posedge clk); #1;
    c_valid[0] = 1'b0;
    saw_rsp = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (b0.rsp_valid) saw_rsp = 1'b1;
    end
    n_checks++;
    if (trig0 != t0 + 1 || saw_rsp !== 1'b0 || b0.cmd_ready !== 1'b0 || b0.mem_push !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_wait: trig=%0d rsp=%b ready=%b push=%b, required 1 0 0 0",
               trig0 - t0, saw_rsp, b0.cmd_ready, b0.mem_push);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({b0.cmd_ready, b0.rsp_valid, b0.mem_trigger, b0.mem_push, b0.rsp_error} !== 5'b0 ||
        b0.depth !== 17'd0 || b0.rsp_a !== 32'd0 || b0.rsp_b !== 32'd0 || b0.mem_write_value !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b valid=%b trig=%b depth=%0d a=%h b=%h, required all 0",
               b0.cmd_ready, b0.rsp_valid, b0.mem_trigger, b0.depth, b0.rsp_a, b0.rsp_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold0 = 1'b0;
    sp = 0;
    @(posedge clk); #1 late_done = 1'b1;
    @(posedge clk); #1 late_done = 1'b0;
    saw_rsp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (b0.rsp_valid) saw_rsp = 1'b1;
    end
    n_checks++;
    if (saw_rsp !== 1'b0 || b0.depth !== 17'd0 || b0.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL late_done: rsp=%b depth=%0d ready=%b, required 0 0 1", saw_rsp, b0.depth, b0.cmd_ready);
    end
    oplog.delete();
    run_cmd(0, 3'b001, 32'h0000_0055, lat, err);
    n_checks++;
    if (lat !== 3 || err !== 1'b0 || b0.depth !== 17'd1 || oplog.size() != 1 ||
        oplog[0] !== {1'b1, 32'h0000_0055}) begin
      n_fail++;
      $display("FAIL push_after_reset: lat=%0d err=%b depth=%0d ops=%0d, required 3 0 1 1",
               lat, err, b0.depth, oplog.size());
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_swap_pop2();
    test_illegal();
    test_dup();
    test_nop();
    test_capacity();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Operand-stack sequencer between the bytecode decode/execute stage and the 32-bit stack memory. It accepts one stack command at a time (PUSH, POP, POP2, DUP, SWAP) and breaks it into single push/pop transactions on the stack memory port. It tracks stack depth and rejects any command that would overflow or underflow. It returns popped operands to the execute stage.

Parameters:
DEPTH_BITS, 16, log2 of stack capacity; capacity = 2^DEPTH_BITS entries (65536 by default, matching the 64K-entry stack memory)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high when a command can be accepted
cmd_op  input  3  000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 SWAP, 101 POP2, others treated as NOP
cmd_value  input  32  value for PUSH
rsp_valid  output  1  one-cycle pulse, command finished
rsp_a  output  32  first popped value (old top)
rsp_b  output  32  second popped value (old top-1)
rsp_error  output  1  qualified by rsp_valid; command rejected
depth  output  DEPTH_BITS+1  current entry count
mem_push  output  1  1 = push, 0 = pop; held for the whole transaction
mem_trigger  output  1  one-cycle transaction start pulse
mem_write_value  output  32  push data; held for the whole transaction
mem_read_value  input  32  pop data, valid when mem_done is high
mem_done  input  1  one-cycle pulse, transaction complete

Behaviour:
- Reset (async, rst_n low): state IDLE, depth 0, rsp_a and rsp_b = 0, every other output 0. Exception: cmd_ready = 1 once rst_n is high.
- Reset mid-transaction: the in-flight memory transaction is abandoned. A late mem_done is ignored in IDLE.
- States: IDLE, POP_A, POP_B, PUSH_1, PUSH_2, RESP.
- IDLE:
  - cmd_ready = 1. A command is accepted on cmd_valid && cmd_ready.
  - cmd_ready = 0 in all other states.
- Legality, checked at accept:
  - PUSH needs depth < 2^DEPTH_BITS.
  - POP and DUP need depth >= 1.
  - SWAP and POP2 need depth >= 2.
  - DUP also needs depth < 2^DEPTH_BITS.
  - Illegal command: go to RESP with rsp_error = 1. No memory traffic, depth unchanged, rsp_a/rsp_b unchanged.
- Micro-op sequences:
  - PUSH: PUSH_1(cmd_value)
  - POP: POP_A
  - POP2: POP_A, POP_B
  - DUP: POP_A, PUSH_1(a), PUSH_2(a)
  - SWAP: POP_A, POP_B, PUSH_1(a), PUSH_2(b). The new top is b.
  - NOP: RESP directly.
- Every micro-op state:
  - mem_trigger pulses for exactly one cycle on state entry.
  - mem_push and mem_write_value are driven from state entry until mem_done.
  - mem_done is honoured from the cycle after trigger onward. Advance on the cycle mem_done is sampled high.
  - Pops capture mem_read_value into rsp_a (POP_A) or rsp_b (POP_B) when mem_done is seen.
  - Wait indefinitely; there is no timeout.
- depth: +1 at each push completion, -1 at each pop completion. Never wraps, because legality is prechecked.
- RESP: rsp_valid = 1 for one cycle, then IDLE. rsp_a/rsp_b hold their values until overwritten.
- Latency with mem_done one cycle after trigger:
  - PUSH: accept at cycle 0, trigger at 1, done at 2, rsp_valid at 3.
  - Each additional micro-op adds 2 cycles.
- cmd_value is latched at accept. Changes after accept have no effect.

Test Plan:
- Reset, then PUSH 0x0000002A; memory model answers done after 1 cycle -> mem_push = 1, mem_write_value = 0x2A, rsp_valid in the 3rd cycle after accept, rsp_error = 0, depth = 1.
- PUSH 5, PUSH 7, SWAP, POP2 -> SWAP issues pop, pop, push 7, push 5. POP2 returns rsp_a = 5, rsp_b = 7. Final depth = 0.
- POP at depth 0 and SWAP at depth 1 -> rsp_error = 1, no mem_trigger, depth unchanged.
- DUP of 0xDEADBEEF at depth 1 -> depth = 2, two pushes of 0xDEADBEEF. Then POP2 gives rsp_a = rsp_b = 0xDEADBEEF.
- DEPTH_BITS = 2 instance: four PUSHes succeed, a fifth gives rsp_error = 1 with depth = 4. DUP at depth 4 is also rejected.
- Hold mem_done low 10 cycles during a POP, assert rst_n low mid-wait -> all outputs 0, depth 0. A late mem_done after release causes no response. A subsequent PUSH works normally.
